// File: rtl/output_register_bank.sv
// Output register bank: queues {port, data} loads in a FIFO and drains them in order to
// per-port display registers. Define OUTREG_BYPASS_EN to let a load skip an empty FIFO.
module output_register_bank #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NPORTS = 2,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PSW   = (NPORTS > 1) ? $clog2(NPORTS) : 1,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic                     CLK,
  input  logic                     nCLR,
  input  logic                     nLo,
  input  logic [WIDTH-1:0]         orin,
  input  logic [PSW-1:0]           psel,
  input  logic [NPORTS-1:0]        disp_busy,
  output logic [NPORTS*WIDTH-1:0]  display,
  output logic [NPORTS-1:0]        disp_stb,
  output logic [CW-1:0]            count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [PSW:0] NPORTS_W = (PSW + 1)'(NPORTS);

  logic [WIDTH-1:0]        r_mem_data [DEPTH];
  logic [PSW-1:0]          r_mem_port [DEPTH];
  logic [AW-1:0]           r_head;
  logic [AW-1:0]           r_tail;
  logic [CW-1:0]           r_count;
  logic                    r_full;
  logic                    r_empty;
  logic                    r_ovf;
  logic [NPORTS*WIDTH-1:0] r_display;
  logic [NPORTS-1:0]       r_stb;

  logic                    w_load;
  logic                    w_bypass;
  logic                    w_push;
  logic                    w_pop;
  logic [PSW-1:0]          w_head_port;
  logic [WIDTH-1:0]        w_head_data;
  logic [CW-1:0]           w_count_d;
  logic [NPORTS*WIDTH-1:0] w_display_d;
  logic [NPORTS-1:0]       w_stb_d;

  // Loads aimed at a nonexistent port are ignored outright.
  assign w_load      = !nLo && ({1'b0, psel} < NPORTS_W);
  assign w_head_port = r_mem_port[r_head];
  assign w_head_data = r_mem_data[r_head];
  assign w_pop       = !r_empty && !disp_busy[w_head_port];

`ifdef OUTREG_BYPASS_EN
  assign w_bypass = w_load && r_empty && !disp_busy[psel];
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push    = w_load && !r_full && !w_bypass;
  assign w_count_d = r_count + CW'(w_push) - CW'(w_pop);

  // Pop and bypass are exclusive: bypass needs an empty FIFO, pop a non-empty one.
  always_comb begin
    w_display_d = r_display;
    w_stb_d     = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (w_pop && (w_head_port == PSW'(p))) begin
        w_display_d[p*WIDTH +: WIDTH] = w_head_data;
        w_stb_d[p]                    = 1'b1;
      end else if (w_bypass && (psel == PSW'(p))) begin
        w_display_d[p*WIDTH +: WIDTH] = orin;
        w_stb_d[p]                    = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_ovf     <= 1'b0;
      r_display <= '0;
      r_stb     <= '0;
    end else begin
      r_head    <= r_head + AW'(w_pop);
      r_tail    <= r_tail + AW'(w_push);
      r_count   <= w_count_d;
      r_full    <= (w_count_d == CW'(DEPTH));
      r_empty   <= (w_count_d == '0);
      r_ovf     <= r_ovf | (w_load & r_full);
      r_display <= w_display_d;
      r_stb     <= w_stb_d;
    end
  end

  // Entry storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem_data[r_tail] <= orin;
      r_mem_port[r_tail] <= psel;
    end
  end

  assign display  = r_display;
  assign disp_stb = r_stb;
  assign count    = r_count;
  assign full     = r_full;
  assign empty    = r_empty;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_output_register_bank.sv
// Directed bench for output_register_bank at WIDTH=8, NPORTS=2, DEPTH=4.
module tb_output_register_bank;

  logic        CLK = 1'b0;
  logic        nCLR = 1'b0;
  logic        nLo = 1'b1;
  logic [7:0]  orin = '0;
  logic [0:0]  psel = '0;
  logic [1:0]  disp_busy = '0;
  logic [15:0] display;
  logic [1:0]  disp_stb;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        ovf;

  int          checks = 0;
  int          errors = 0;
  int          log_port[$];
  logic [7:0]  log_data[$];
  int          max_count = 0;

  output_register_bank #(
    .WIDTH (8),
    .NPORTS(2),
    .DEPTH (4)
  ) dut (
    .CLK      (CLK),
    .nCLR     (nCLR),
    .nLo      (nLo),
    .orin     (orin),
    .psel     (psel),
    .disp_busy(disp_busy),
    .display  (display),
    .disp_stb (disp_stb),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .ovf      (ovf)
  );

  always #5 CLK = ~CLK;

  // Record every strobe with the value its port shows, and track peak occupancy.
  always @(posedge CLK) begin
    #2;
    for (int p = 0; p < 2; p++) begin
      if (disp_stb[p]) begin
        log_port.push_back(p);
        log_data.push_back(display[p*8 +: 8]);
      end
    end
    if (int'(count) > max_count) max_count = int'(count);
  end

  task automatic do_load(input logic [7:0] d, input logic [0:0] p);
    nLo  = 1'b0;
    orin = d;
    psel = p;
    @(posedge CLK);
    #1;
    nLo = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (display !== 16'h0000) begin errors++; $display("FAIL reset_display: got %h expected 0000", display); end
    checks++; if (disp_stb !== 2'b00) begin errors++; $display("FAIL reset_stb: got %b expected 00", disp_stb); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    nCLR = 1'b1;
  endtask

  task automatic test_single();
    logic [8:0] got;
    log_port.delete(); log_data.delete();
    disp_busy = 2'b00;
    do_load(8'h5A, 1'b0);
    do_load(8'hC3, 1'b1);
    repeat (6) @(negedge CLK);
    checks++; if (log_port.size() !== 2) begin errors++; $display("FAIL single_strobes: got %0d expected 2", log_port.size()); end
    got = (log_port.size() > 0) ? {log_port[0][0], log_data[0]} : 9'h1FF;
    checks++; if (got !== 9'h05A) begin errors++; $display("FAIL single_first: got %h expected 05a", got); end
    got = (log_port.size() > 1) ? {log_port[1][0], log_data[1]} : 9'h1FF;
    checks++; if (got !== 9'h1C3) begin errors++; $display("FAIL single_second: got %h expected 1c3", got); end
    checks++; if (display !== 16'hC35A) begin errors++; $display("FAIL single_display: got %h expected c35a", display); end
  endtask

  task automatic test_overflow();
    logic [8:0] got;
    logic [8:0] exp_q[4] = '{9'h011, 9'h122, 9'h033, 9'h144};
    log_port.delete(); log_data.delete();
    disp_busy = 2'b11;
    do_load(8'h11, 1'b0);
    do_load(8'h22, 1'b1);
    do_load(8'h33, 1'b0);
    do_load(8'h44, 1'b1);
    @(negedge CLK);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count4: got %0d expected 4", count); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", full); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", ovf); end
    do_load(8'h55, 1'b0);
    @(negedge CLK);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ovf); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count_hold: got %0d expected 4", count); end
    disp_busy = 2'b00;
    repeat (8) @(negedge CLK);
    checks++; if (log_port.size() !== 4) begin errors++; $display("FAIL ovf_drain_n: got %0d expected 4", log_port.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (log_port.size() > i) ? {log_port[i][0], log_data[i]} : 9'h1FF;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL ovf_drain_%0d: got %h expected %h", i, got, exp_q[i]); end
    end
    checks++; if (display !== 16'h4433) begin errors++; $display("FAIL ovf_display: got %h expected 4433", display); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %b expected 1", empty); end
  endtask

  task automatic test_hol();
    logic [8:0] got;
    logic [8:0] exp_q[3] = '{9'h1A1, 9'h0B0, 9'h1C1};
    log_port.delete(); log_data.delete();
    disp_busy = 2'b10;
    do_load(8'hA1, 1'b1);
    do_load(8'hB0, 1'b0);
    do_load(8'hC1, 1'b1);
    repeat (4) @(negedge CLK);
    checks++; if (log_port.size() !== 0) begin errors++; $display("FAIL hol_stalled: got %0d strobes expected 0", log_port.size()); end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL hol_count: got %0d expected 3", count); end
    checks++; if (display !== 16'h4433) begin errors++; $display("FAIL hol_hold: got %h expected 4433", display); end
    disp_busy = 2'b00;
    repeat (6) @(negedge CLK);
    checks++; if (log_port.size() !== 3) begin errors++; $display("FAIL hol_drain_n: got %0d expected 3", log_port.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (log_port.size() > i) ? {log_port[i][0], log_data[i]} : 9'h1FF;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL hol_order_%0d: got %h expected %h", i, got, exp_q[i]); end
    end
    checks++; if (display !== 16'hC1B0) begin errors++; $display("FAIL hol_display: got %h expected c1b0", display); end
  endtask

  task automatic test_wrap();
    logic [8:0] got;
    logic [8:0] exp;
    log_port.delete(); log_data.delete();
    disp_busy = 2'b00;
    max_count = 0;
    for (int i = 0; i < 10; i++) do_load(8'h10 + 8'(i), 1'(i % 2));
    repeat (6) @(negedge CLK);
    checks++; if (log_port.size() !== 10) begin errors++; $display("FAIL wrap_n: got %0d expected 10", log_port.size()); end
    for (int i = 0; i < 10; i++) begin
      exp = {1'(i % 2), 8'h10 + 8'(i)};
      got = (log_port.size() > i) ? {log_port[i][0], log_data[i]} : 9'h1FF;
      checks++; if (got !== exp) begin errors++; $display("FAIL wrap_order_%0d: got %h expected %h", i, got, exp); end
    end
    checks++; if (max_count > 1) begin errors++; $display("FAIL wrap_maxcount: got %0d expected <=1", max_count); end
    checks++; if (display !== 16'h1918) begin errors++; $display("FAIL wrap_display: got %h expected 1918", display); end
  endtask

  task automatic test_bypass();
    logic [7:0] exp_d0;
    logic [2:0] exp_c0;
    logic [1:0] exp_s0;
    logic [1:0] exp_s1;
`ifdef OUTREG_BYPASS_EN
    exp_d0 = 8'h77; exp_c0 = 3'd0; exp_s0 = 2'b01; exp_s1 = 2'b00;
`else
    exp_d0 = 8'h18; exp_c0 = 3'd1; exp_s0 = 2'b00; exp_s1 = 2'b01;
`endif
    @(negedge CLK);
    disp_busy = 2'b00;
    do_load(8'h77, 1'b0);
    checks++; if (display[7:0] !== exp_d0) begin errors++; $display("FAIL byp_edge_n_display: got %h expected %h", display[7:0], exp_d0); end
    checks++; if (count !== exp_c0) begin errors++; $display("FAIL byp_edge_n_count: got %0d expected %0d", count, exp_c0); end
    checks++; if (disp_stb !== exp_s0) begin errors++; $display("FAIL byp_edge_n_stb: got %b expected %b", disp_stb, exp_s0); end
    @(posedge CLK);
    #1;
    checks++; if (display[7:0] !== 8'h77) begin errors++; $display("FAIL byp_edge_n1_display: got %h expected 77", display[7:0]); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL byp_edge_n1_count: got %0d expected 0", count); end
    checks++; if (disp_stb !== exp_s1) begin errors++; $display("FAIL byp_edge_n1_stb: got %b expected %b", disp_stb, exp_s1); end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    disp_busy = 2'b11;
    do_load(8'h91, 1'b0);
    do_load(8'h92, 1'b1);
    do_load(8'h93, 1'b0);
    do_load(8'h94, 1'b1);
    do_load(8'h95, 1'b0);
    @(negedge CLK);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL rst_pre_ovf: got %b expected 1", ovf); end
    #2;
    nCLR = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_mid_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_mid_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_mid_full: got %b expected 0", full); end
    checks++; if (display !== 16'h0000) begin errors++; $display("FAIL rst_mid_display: got %h expected 0000", display); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf: got %b expected 0", ovf); end
    @(negedge CLK);
    disp_busy = 2'b00;
    log_port.delete(); log_data.delete();
    nCLR = 1'b1;
    repeat (8) @(negedge CLK);
    checks++; if (log_port.size() !== 0) begin errors++; $display("FAIL rst_no_stb: got %0d strobes expected 0", log_port.size()); end
    checks++; if (display !== 16'h0000) begin errors++; $display("FAIL rst_post_display: got %h expected 0000", display); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_post_count: got %0d expected 0", count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_hol();
    test_wrap();
    test_bypass();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
